// File: rtl/pla_decode_sched_pkg.sv
// Shared types and constants for the PLA decode-core scheduler.
// This package is imported by the arbiter, the interface users and the top.
package pla_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DW_IN_DEF  = 4;
    localparam int DW_OUT_DEF = 7;
    localparam int TXN_CNT_W  = 16;

    // Index width that never collapses to zero bits for tiny ranges.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pla_decode_sched_if.sv
// Requester-side bus of the decode scheduler: request channel and response channel.
// A channel transfers on a clock edge where valid and ready are both high.
// The request source holds its valid and data stable until ready is seen.
// Ready may depend combinationally on valid. The response side follows the same rule.
interface pla_decode_sched_if #(
    parameter int NREQ   = 4,
    parameter int DW_IN  = 4,
    parameter int DW_OUT = 7
) ();
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DW_IN-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [DW_OUT-1:0]     rsp_data;
    logic [NREQ-1:0]       rsp_ready;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/pla_decode_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Priority starts at the slot after ptr_i and wraps around once.
module rr_arbiter
    import pla_sched_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IW  = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   gnt_idx_o,
    output logic            any_o
);

    logic found;

    always_comb begin
        found     = 1'b0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && req_i[j] && (j == (int'(ptr_i) + k) % NREQ)) begin
                    found     = 1'b1;
                    gnt_o[j]  = 1'b1;
                    gnt_idx_o = IW'(j);
                end
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/pla_decode_sched.sv
// Time-shares one combinational decode core among NREQ requesters.
// The core input is registered and only changes on accept, so an idle core does not toggle.
module pla_decode_sched
    import pla_sched_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DW_IN     = DW_IN_DEF,
    parameter int DW_OUT    = DW_OUT_DEF,
    parameter int DEC_LAT   = 1,
    parameter int HOLD_IDLE = 1,
    localparam int IW       = idx_w(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pla_decode_sched_if.slave    bus,
    output logic [DW_IN-1:0]     dec_in,
    input  logic [DW_OUT-1:0]    dec_out,
    output logic                 dec_en,
    output logic                 busy,
    output logic [IW-1:0]        grant_id,
    output logic [TXN_CNT_W-1:0] txn_count,
    output state_t               state_o
);

    localparam int CNT_W = idx_w(DEC_LAT);

    state_t                 state_q;
    logic [IW-1:0]          rr_ptr_q;
    logic [IW-1:0]          grant_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [DW_IN-1:0]       dec_in_q;
    logic [DW_OUT-1:0]      rsp_data_q;
    logic [TXN_CNT_W-1:0]   txn_q;

    logic [NREQ-1:0]        arb_gnt;
    logic [IW-1:0]          arb_idx;
    logic                   arb_any;
    logic [DW_IN-1:0]       operand;
    logic                   rsp_ack;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i     (bus.req_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx),
        .any_o     (arb_any)
    );

    // AND-OR select keeps the operand mux free of a wide index decode.
    always_comb begin
        operand = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) operand = operand | bus.req_data[i*DW_IN +: DW_IN];
        end
    end

    assign rsp_ack = bus.rsp_ready[grant_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= IW'(NREQ - 1);
            grant_q    <= '0;
            cnt_q      <= '0;
            dec_in_q   <= '0;
            rsp_data_q <= '0;
            txn_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        dec_in_q <= operand;
                        grant_q  <= arb_idx;
                        cnt_q    <= CNT_W'(DEC_LAT - 1);
                        state_q  <= EVAL;
                    end else if (HOLD_IDLE == 0) begin
                        dec_in_q <= '0;
                    end
                end
                EVAL: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        rsp_data_q <= dec_out;
                        state_q    <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ack) begin
                        rr_ptr_q <= grant_q;
                        if (txn_q != '1) txn_q <= txn_q + 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state_q == IDLE) ? arb_gnt : '0;

    always_comb begin
        bus.rsp_valid = '0;
        if (state_q == RESP) bus.rsp_valid[grant_q] = 1'b1;
    end

    assign bus.rsp_data = rsp_data_q;
    assign dec_in       = dec_in_q;
    assign dec_en       = (state_q == EVAL);
    assign busy         = (state_q != IDLE);
    assign grant_id     = grant_q;
    assign txn_count    = txn_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_pla_decode_sched.sv
// Bench for pla_decode_sched: two instances (DEC_LAT=1/hold idle, DEC_LAT=4/zero idle)
// with directed vectors, corner sequences and a randomized run against a cycle-level model.
module tb_pla_decode_sched;
    import pla_sched_pkg::*;

    localparam int N     = 4;
    localparam int LAT_A = 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cycle_no = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle_no <= cycle_no + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs and core stubs ----------------
    pla_decode_sched_if #(.NREQ(N), .DW_IN(4), .DW_OUT(7)) bus_a ();
    pla_decode_sched_if #(.NREQ(N), .DW_IN(4), .DW_OUT(7)) bus_b ();

    logic [3:0]  dec_in_a, dec_in_b;
    logic [6:0]  dec_out_a, dec_out_b;
    logic        dec_en_a, dec_en_b, busy_a, busy_b;
    logic [1:0]  gid_a, gid_b;
    logic [15:0] txn_a, txn_b;
    state_t      st_a, st_b;
    logic [6:0]  stub_cnt = '0;

    always @(posedge clk) stub_cnt <= stub_cnt + 7'd1;
    assign dec_out_a = {3'b000, dec_in_a} ^ 7'h55;
    assign dec_out_b = {3'b000, dec_in_b} ^ stub_cnt;

    pla_decode_sched #(.NREQ(N), .DEC_LAT(LAT_A), .HOLD_IDLE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave),
        .dec_in(dec_in_a), .dec_out(dec_out_a), .dec_en(dec_en_a), .busy(busy_a),
        .grant_id(gid_a), .txn_count(txn_a), .state_o(st_a)
    );

    pla_decode_sched #(.NREQ(N), .DEC_LAT(4), .HOLD_IDLE(0)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave),
        .dec_in(dec_in_b), .dec_out(dec_out_b), .dec_en(dec_en_b), .busy(busy_b),
        .grant_id(gid_b), .txn_count(txn_b), .state_o(st_b)
    );

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_one_a(input int idx, input logic [3:0] d);
        bus_a.req_valid = 4'b0001 << idx;
        bus_a.req_data  = '0;
        bus_a.req_data[idx*4 +: 4] = d;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, " dec_in"},    dec_in_a, 0);
        chk({tag, " rsp_data"},  bus_a.rsp_data, 0);
        chk({tag, " grant_id"},  gid_a, 0);
        chk({tag, " txn_count"}, txn_a, 0);
        chk({tag, " req_ready"}, bus_a.req_ready, 0);
        chk({tag, " rsp_valid"}, bus_a.rsp_valid, 0);
        chk({tag, " dec_en"},    dec_en_a, 0);
        chk({tag, " busy"},      busy_a, 0);
        chk({tag, " state"},     st_a, IDLE);
    endtask

    // ---------------- scoreboard / reference model ----------------
    logic [6:0] exp_q[$];
    logic [3:0] rv;
    logic [3:0] rd [N];
    int  m_last, m_owner, m_resp_at, m_cyc, m_cnt;
    bit  m_free;

    // Whole-transaction model: a grant opens a window that yields a response
    // DEC_LAT+1 cycles later and closes when the owner accepts it.
    task automatic rand_run(input int ncyc);
        logic [3:0] exp_rdy, exp_vld, acc;
        logic [6:0] exp_d;
        int win, j;
        acc = '0;
        for (int c = 0; c < ncyc; c++) begin
            next_cycle();
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    rv[i] = 1'b0;
                    rd[i] = 4'($urandom_range(0, 15));
                end else if (!rv[i]) begin
                    if ($urandom_range(0, 99) < 35) begin
                        rv[i] = 1'b1;
                        rd[i] = 4'($urandom_range(0, 15));
                    end
                end else if ($urandom_range(0, 99) < 5) begin
                    rv[i] = 1'b0;
                end else if ($urandom_range(0, 99) < 10) begin
                    rd[i] = 4'($urandom_range(0, 15));
                end
                bus_a.req_data[i*4 +: 4] = rd[i];
            end
            acc = '0;
            bus_a.req_valid = rv;
            bus_a.rsp_ready = 4'($urandom_range(0, 15));
            settle();

            exp_rdy = '0;
            exp_vld = '0;
            win = -1;
            if (m_free) begin
                for (int k = 1; k <= N; k++) begin
                    j = (m_last + k) % N;
                    if (win < 0 && rv[j]) win = j;
                end
                if (win >= 0) exp_rdy[win] = 1'b1;
            end else if (m_cyc >= m_resp_at) begin
                exp_vld[m_owner] = 1'b1;
            end

            chk("rnd req_ready", bus_a.req_ready, exp_rdy);
            chk("rnd rsp_valid", bus_a.rsp_valid, exp_vld);
            chk("rnd busy", busy_a, !m_free);
            chk("rnd txn_count", txn_a, m_cnt);
            chk("rnd dec_en", dec_en_a, (!m_free && m_cyc < m_resp_at));
            if (!m_free) chk("rnd grant_id", gid_a, m_owner);
            if (exp_vld != 0 && exp_q.size() > 0) chk("rnd rsp_data", bus_a.rsp_data, exp_q[0]);

            if (win >= 0) begin
                m_free    = 1'b0;
                m_owner   = win;
                m_resp_at = m_cyc + LAT_A + 1;
                exp_d     = {3'b000, rd[win]} ^ 7'h55;
                exp_q.push_back(exp_d);
                acc[win]  = 1'b1;
            end else if (exp_vld != 0 && bus_a.rsp_ready[m_owner]) begin
                m_free = 1'b1;
                m_last = m_owner;
                if (m_cnt < 65535) m_cnt++;
                void'(exp_q.pop_front());
            end
            m_cyc++;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         idx;
        logic [3:0] data;
        logic [6:0] exp_rsp;
    } vec_t;

    vec_t vecs [6];
    int   order [5];

    initial begin
        logic [6:0] c_b, exp_b;
        int n_en, lat, prev_rsp;
        bit found;

        vecs[0] = '{0, 4'hA, 7'h5F};
        vecs[1] = '{1, 4'h0, 7'h55};
        vecs[2] = '{2, 4'hF, 7'h5A};
        vecs[3] = '{0, 4'h3, 7'h56};
        vecs[4] = '{2, 4'hC, 7'h59};
        vecs[5] = '{3, 4'h7, 7'h52};
        order   = '{0, 1, 2, 3, 0};

        bus_a.req_valid = '0; bus_a.req_data = '0; bus_a.rsp_ready = '1;
        bus_b.req_valid = '0; bus_b.req_data = '0; bus_b.rsp_ready = '1;
        rv = '0;
        for (int i = 0; i < N; i++) rd[i] = '0;

        // Reset state
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        settle();
        chk_reset_a("reset");
        chk("reset b dec_in", dec_in_b, 0);
        chk("reset b busy", busy_b, 0);

        // Single-request table, rsp_ready held high in advance
        for (int v = 0; v < 6; v++) begin
            drive_one_a(vecs[v].idx, vecs[v].data);
            settle();
            chk("vec req_ready", bus_a.req_ready, 4'b0001 << vecs[v].idx);
            next_cycle();
            bus_a.req_valid = '0;
            bus_a.req_data  = '1;
            settle();
            chk("vec dec_en", dec_en_a, 1);
            chk("vec dec_in", dec_in_a, vecs[v].data);
            chk("vec no early rsp", bus_a.rsp_valid, 0);
            next_cycle();
            settle();
            chk("vec rsp_valid", bus_a.rsp_valid, 4'b0001 << vecs[v].idx);
            chk("vec rsp_data", bus_a.rsp_data, vecs[v].exp_rsp);
            chk("vec grant_id", gid_a, vecs[v].idx);
            next_cycle();
            settle();
            chk("vec txn_count", txn_a, v + 1);
            chk("vec idle", busy_a, 0);
        end

        // All four requesters valid continuously
        bus_a.req_valid = 4'b1111;
        bus_a.req_data  = {4'h4, 4'h3, 4'h2, 4'h1};
        prev_rsp = 0;
        for (int g = 0; g < 5; g++) begin
            settle();
            chk("rr req_ready", bus_a.req_ready, 4'b0001 << order[g]);
            next_cycle();
            next_cycle();
            settle();
            chk("rr rsp_valid", bus_a.rsp_valid, 4'b0001 << order[g]);
            chk("rr rsp_data", bus_a.rsp_data, {3'b000, 4'(order[g] + 1)} ^ 7'h55);
            if (g > 0) chk("rr rsp spacing", cycle_no - prev_rsp, 3);
            prev_rsp = cycle_no;
            if (g == 4) bus_a.req_valid = '0;
            next_cycle();
        end
        settle();
        chk("rr txn_count", txn_a, 11);
        chk("rr idle", busy_a, 0);

        // Backpressure on requester 2
        bus_a.req_valid = 4'b0100;
        bus_a.req_data  = {4'h4, 4'h9, 4'h2, 4'h1};
        bus_a.rsp_ready = 4'b1011;
        settle();
        chk("bp req_ready", bus_a.req_ready, 4'b0100);
        next_cycle();
        bus_a.req_valid = 4'b1111;
        settle();
        chk("bp eval req_ready", bus_a.req_ready, 0);
        next_cycle();
        for (int r = 0; r < 10; r++) begin
            settle();
            chk("bp rsp_valid", bus_a.rsp_valid, 4'b0100);
            chk("bp rsp_data", bus_a.rsp_data, 7'h5C);
            chk("bp req_ready", bus_a.req_ready, 0);
            next_cycle();
        end
        bus_a.rsp_ready = 4'b1111;
        settle();
        chk("bp rsp_valid at ready", bus_a.rsp_valid, 4'b0100);
        next_cycle();
        settle();
        chk("bp done rsp_valid", bus_a.rsp_valid, 0);
        chk("bp txn_count", txn_a, 12);
        chk("bp next winner", bus_a.req_ready, 4'b1000);
        bus_a.req_valid = '0;
        settle();
        chk("bp dropped valid", bus_a.req_ready, 0);
        next_cycle();
        settle();
        chk("bp dropped no accept", busy_a, 0);
        chk("bp dec_in held", dec_in_a, 4'h9);

        // Idle isolation with HOLD_IDLE=1
        drive_one_a(1, 4'h7);
        settle();
        chk("iso req_ready", bus_a.req_ready, 4'b0010);
        next_cycle();
        bus_a.req_valid = '0;
        next_cycle();
        settle();
        chk("iso rsp_data", bus_a.rsp_data, 7'h52);
        next_cycle();
        for (int k = 0; k < 20; k++) begin
            settle();
            chk("iso dec_in held", dec_in_a, 4'h7);
            chk("iso dec_en", dec_en_a, 0);
            next_cycle();
        end

        // DEC_LAT=4 with a moving stub, then HOLD_IDLE=0 zeroing
        bus_b.req_valid = 4'b0001;
        bus_b.req_data  = {12'h000, 4'h7};
        settle();
        chk("b req_ready", bus_b.req_ready, 4'b0001);
        c_b = stub_cnt;
        exp_b = {3'b000, 4'h7} ^ (c_b + 7'd4);
        next_cycle();
        bus_b.req_valid = '0;
        n_en = 0;
        lat = 0;
        found = 1'b0;
        while (!found && lat < 12) begin
            settle();
            if (bus_b.rsp_valid != 0) begin
                found = 1'b1;
            end else begin
                if (dec_en_b) n_en++;
                chk("b dec_in stable", dec_in_b, 4'h7);
                next_cycle();
                lat++;
            end
        end
        chk("b rsp seen", found, 1);
        chk("b dec_en cycles", n_en, 4);
        chk("b latency", lat, 4);
        chk("b rsp_valid", bus_b.rsp_valid, 4'b0001);
        chk("b rsp_data", bus_b.rsp_data, exp_b);
        chk("b dec_en in resp", dec_en_b, 0);
        next_cycle();
        next_cycle();
        for (int k = 0; k < 18; k++) begin
            settle();
            chk("b idle dec_in zero", dec_in_b, 0);
            chk("b idle dec_en", dec_en_b, 0);
            next_cycle();
        end

        // Reset during EVAL abandons the transaction
        drive_one_a(2, 4'h5);
        settle();
        chk("rst req_ready", bus_a.req_ready, 4'b0100);
        next_cycle();
        bus_a.req_valid = '0;
        settle();
        chk("rst in eval", dec_en_a, 1);
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        settle();
        chk_reset_a("mid-reset");
        bus_a.req_valid = 4'b1111;
        bus_a.req_data  = {4'h4, 4'h3, 4'h2, 4'h1};
        settle();
        chk("post-reset first grant", bus_a.req_ready, 4'b0001);
        next_cycle();
        bus_a.req_valid = '0;
        next_cycle();
        settle();
        chk("post-reset rsp_valid", bus_a.rsp_valid, 4'b0001);
        chk("post-reset rsp_data", bus_a.rsp_data, 7'h54);
        next_cycle();
        settle();
        chk("post-reset txn_count", txn_a, 1);

        // Randomized run against the model
        bus_a.req_valid = '0;
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        m_last = N - 1;
        m_free = 1'b1;
        m_cnt  = 0;
        m_cyc  = 0;
        m_owner = 0;
        m_resp_at = 0;
        rv = '0;
        exp_q.delete();
        rand_run(1500);

        bus_a.req_valid = '0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
